sram_wait_ctrl: RTL and testbench
=================================

SRAM_WAIT_CTRL -- requirements
Module: sram_wait_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, 32, data bus width in bits (multiple of 8).
REQ-002 SHALL provide parameter ADDR_W, 16, SRAM word-address width.
REQ-003 SHALL provide parameter BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0.
REQ-004 SHALL provide parameter WAIT_CYCLES, 5, SRAM access cycles (legal range 2..15).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port MEM_R_EN  input  1  read request from MEM stage.
REQ-008 SHALL have port MEM_W_EN  input  1  write request from MEM stage.
REQ-009 SHALL have port address  input  32  CPU byte address.
REQ-010 SHALL have port write_data  input  DATA_W  store data.
REQ-011 SHALL have port read_data  output  DATA_W  registered load data.
REQ-012 SHALL have port ready  output  1  low = pipeline must stall.
REQ-013 SHALL have port addr_err  output  1  access was out of SRAM range.
REQ-014 SHALL have port data_SRAM  inout  DATA_W  SRAM data bus.
REQ-015 SHALL have port address_SRAM  output  ADDR_W  registered SRAM word address.
REQ-016 SHALL have port WE_N_SRAM  output  1  SRAM write enable, active-low, registered.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE plus a wait counter cnt.
REQ-018 SHALL compute word address as (address - BASE_ADDR) >> 2, truncated to ADDR_W; address[1:0] ignored.
REQ-019 SHALL flag out of range when address < BASE_ADDR or (address - BASE_ADDR) >> 2 >= 2^ADDR_W.
REQ-020 SHALL drive ready = 1 in IDLE with no request, 0 in IDLE with request, 0 in ACCESS, 1 in DONE (combinational).
REQ-021 IDLE with request and in range: on next edge latch op, address_SRAM, write data; cnt=0; enter ACCESS.
REQ-022 IDLE with request and out of range: on next edge enter DONE directly, no SRAM cycle, WE_N_SRAM stays 1, addr_err=1 in DONE.
REQ-023 SHALL give write priority when MEM_R_EN and MEM_W_EN are both high.
REQ-024 ACCESS: cnt increments each edge; at edge with cnt == WAIT_CYCLES-1 enter DONE.
REQ-025 Write: WE_N_SRAM = 0 while ACCESS and cnt < WAIT_CYCLES-1; 1 on last ACCESS cycle (address/data hold).
REQ-026 Write: data_SRAM driven with latched write data for all ACCESS cycles; high-Z in every other state and for reads.
REQ-027 Read: read_data captured from data_SRAM on the edge leaving ACCESS; read_data holds until next completed in-range read.
REQ-028 Out-of-range read SHALL set read_data to 0.
REQ-029 DONE lasts exactly one cycle, then IDLE unconditionally; a request still held is treated as a new access.
REQ-030 Dropping MEM_R_EN/MEM_W_EN or changing address during ACCESS SHALL NOT alter the in-flight access.
REQ-031 Request-to-ready latency SHALL be WAIT_CYCLES+1 low cycles, ready high on the following cycle.
REQ-032 addr_err SHALL be high only in DONE of an out-of-range access, else 0.

Reset
REQ-033 On rst: state IDLE, cnt 0, read_data 0, address_SRAM 0, WE_N_SRAM 1, addr_err 0, data_SRAM high-Z, immediately.
REQ-034 rst mid-ACCESS SHALL abort the access (WE_N_SRAM to 1 asynchronously); no retry after release.

Verification
REQ-035 Write 0xDEADBEEF to 1032, WAIT_CYCLES=5 -> address_SRAM=2, WE_N_SRAM low 4 cycles, ready low 6 cycles then high 1 cycle.
REQ-036 Read 1032 after REQ-035 with SRAM model -> read_data=0xDEADBEEF in DONE cycle, data_SRAM high-Z throughout.
REQ-037 Read 512 -> ready low 1 cycle, DONE with addr_err=1, read_data=0, WE_N_SRAM never low.
REQ-038 MEM_R_EN and MEM_W_EN both high at 1028 -> write performed to word 1, read_data unchanged.
REQ-039 rst pulse at ACCESS cnt=2 of a write -> WE_N_SRAM=1, ready=1, state IDLE, no completion after release.
REQ-040 Back-to-back writes to 1024 and 1028 held continuously -> two separate 7-cycle transactions, words 0 and 1.

Source files
------------

// File: rtl/sram_wait_ctrl.sv
// Wait-state controller bridging a CPU MEM stage to an asynchronous single-port SRAM.
// Each in-range access holds the SRAM bus for WAIT_CYCLES clocks and stalls the pipeline via ready.
module sram_wait_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              ready,
    output logic              addr_err,
    inout  wire  [DATA_W-1:0] data_SRAM,
    output logic [ADDR_W-1:0] address_SRAM,
    output logic              WE_N_SRAM
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] asram_q, asram_d;
    logic              we_n_q, we_n_d;
    logic              err_q, err_d;

    logic [31:0] offset;
    logic [31:0] word_full;
    logic        out_of_range;
    logic        req;

    // Byte offset from the SRAM window base, then word index; low two address bits drop out.
    assign offset       = address - BASE_ADDR;
    assign word_full    = offset >> 2;
    assign out_of_range = (address < BASE_ADDR) || ((word_full >> ADDR_W) != 32'd0);
    assign req          = MEM_R_EN | MEM_W_EN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        asram_d = asram_q;
        we_n_d  = 1'b1;
        err_d   = 1'b0;
        ready   = 1'b0;

        case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    if (out_of_range) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!MEM_W_EN) begin
                            rdata_d = '0;
                        end
                    end else begin
                        // Write wins when both enables are asserted.
                        state_d = ACCESS;
                        cnt_d   = '0;
                        op_wr_d = MEM_W_EN;
                        wdata_d = write_data;
                        asram_d = ADDR_W'(word_full);
                        we_n_d  = ~MEM_W_EN;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_wr_q) begin
                        rdata_d = data_SRAM;
                    end
                end else begin
                    // Release WE one cycle early so address/data hold past the write strobe.
                    we_n_d = ~(op_wr_q && (cnt_d < LAST_CNT));
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            asram_q <= '0;
            we_n_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            asram_q <= asram_d;
            we_n_q  <= we_n_d;
            err_q   <= err_d;
        end
    end

    assign data_SRAM    = (state_q == ACCESS && op_wr_q) ? wdata_q : {DATA_W{1'bz}};
    assign read_data    = rdata_q;
    assign address_SRAM = asram_q;
    assign WE_N_SRAM    = we_n_q;
    assign addr_err     = err_q;

endmodule

// File: tb/tb_sram_wait_ctrl.sv
// Bench for sram_wait_ctrl: directed vector table, hand-written corner sequences,
// and random transactions checked against a transaction-level model with an SRAM array.
module tb_sram_wait_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WAIT   = 5;
    localparam logic [31:0] BASE   = 32'd1024;
    localparam int unsigned WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              MEM_R_EN, MEM_W_EN;
    logic [31:0]       address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready, addr_err, WE_N_SRAM;
    logic [ADDR_W-1:0] address_SRAM;
    wire  [DATA_W-1:0] data_SRAM;

    sram_wait_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)
    ) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .addr_err(addr_err), .data_SRAM(data_SRAM),
        .address_SRAM(address_SRAM), .WE_N_SRAM(WE_N_SRAM)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives the bus when output-enabled and not being written.
    logic [DATA_W-1:0] sram [0:WORDS-1];
    logic              sram_oe;
    assign data_SRAM = (sram_oe && WE_N_SRAM) ? sram[address_SRAM] : {DATA_W{1'bz}};
    always @(posedge clk) if (!WE_N_SRAM) sram[address_SRAM] <= data_SRAM;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: memory contents plus the last visible read_data / word address.
    logic [DATA_W-1:0] mmem [0:WORDS-1];
    logic [DATA_W-1:0] m_rdata;
    logic [ADDR_W-1:0] m_asram;

    typedef struct {
        int low; int we; logic err; logic [DATA_W-1:0] rdata; logic [ADDR_W-1:0] asram;
    } exp_t;

    task automatic model_txn(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [DATA_W-1:0] wdata, output exp_t e);
        longint unsigned a = 64'(addr);
        bit oor = (a < 64'(BASE)) || (((a - 64'(BASE)) / 4) >= 64'(WORDS));
        int word = 0;
        if (!oor) word = int'((a - 64'(BASE)) / 4);
        if (!oor) m_asram = ADDR_W'(word);
        if (wr && !oor) mmem[word] = wdata;
        else if (rd && !wr) m_rdata = oor ? '0 : mmem[word];
        e.low   = oor ? 1 : WAIT + 1;
        e.we    = (wr && !oor) ? WAIT - 1 : 0;
        e.err   = oor;
        e.rdata = m_rdata;
        e.asram = m_asram;
    endtask

    typedef struct {
        int low; int we; int busbad; logic err; logic [DATA_W-1:0] rdata; logic [ADDR_W-1:0] asram;
    } obs_t;

    // Present a request, count stall cycles until ready, then sample the DONE-cycle outputs.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [DATA_W-1:0] wdata, input bit scramble, input bit drop,
                           output obs_t o);
        o = '{low: 0, we: 0, busbad: 0, err: 1'b0, rdata: '0, asram: '0};
        @(negedge clk);
        MEM_R_EN = rd; MEM_W_EN = wr; address = addr; write_data = wdata;
        sram_oe = rd && !wr;
        #1;
        for (int i = 0; i < 40 && !ready; i++) begin
            o.low++;
            if (!WE_N_SRAM) o.we++;
            if (o.low >= 2 && wr && data_SRAM !== wdata) o.busbad++;
            if (o.low >= 2 && rd && !wr && data_SRAM !== sram[address_SRAM]) o.busbad++;
            if (scramble && o.low == 2) begin
                MEM_R_EN = 1'($urandom); MEM_W_EN = 1'($urandom);
                address = $urandom; write_data = $urandom;
            end
            @(negedge clk); #1;
        end
        o.err = addr_err; o.rdata = read_data; o.asram = address_SRAM;
        if (drop) begin MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; end
    endtask

    task automatic cmp_obs(input string tag, input obs_t o, input exp_t e);
        check({tag, ".low_cycles"}, 64'(o.low), 64'(e.low));
        check({tag, ".we_low"},     64'(o.we),  64'(e.we));
        check({tag, ".addr_err"},   64'(o.err), 64'(e.err));
        check({tag, ".read_data"},  64'(o.rdata), 64'(e.rdata));
        check({tag, ".addr_sram"},  64'(o.asram), 64'(e.asram));
        check({tag, ".bus"},        64'(o.busbad), 64'd0);
    endtask

    typedef struct {
        logic rd; logic wr; logic [31:0] addr; logic [DATA_W-1:0] wdata; exp_t e;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs [9];
        obs_t  o;
        exp_t  e;
        int    cnt_lo, cnt_we;

        vecs[0] = '{1'b0, 1'b1, 32'd1032,   32'hDEADBEEF, '{6, 4, 1'b0, 32'h0,        16'd2}};
        vecs[1] = '{1'b1, 1'b0, 32'd1032,   32'h0,        '{6, 0, 1'b0, 32'hDEADBEEF, 16'd2}};
        vecs[2] = '{1'b1, 1'b0, 32'd512,    32'h0,        '{1, 0, 1'b1, 32'h0,        16'd2}};
        vecs[3] = '{1'b1, 1'b1, 32'd1028,   32'h12345678, '{6, 4, 1'b0, 32'h0,        16'd1}};
        vecs[4] = '{1'b1, 1'b0, 32'd1028,   32'h0,        '{6, 0, 1'b0, 32'h12345678, 16'd1}};
        vecs[5] = '{1'b0, 1'b1, 32'd263166, 32'hA5A50001, '{6, 4, 1'b0, 32'h12345678, 16'hFFFF}};
        vecs[6] = '{1'b0, 1'b1, 32'd263168, 32'h55555555, '{1, 0, 1'b1, 32'h12345678, 16'hFFFF}};
        vecs[7] = '{1'b1, 1'b0, 32'd1023,   32'h0,        '{1, 0, 1'b1, 32'h0,        16'hFFFF}};
        vecs[8] = '{1'b1, 1'b0, 32'd263167, 32'h0,        '{6, 0, 1'b0, 32'hA5A50001, 16'hFFFF}};

        for (int i = 0; i < int'(WORDS); i++) begin sram[i] = '0; mmem[i] = '0; end
        m_rdata = '0; m_asram = '0;

        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; write_data = '0; sram_oe = 1'b0;
        #2;
        check("rst.ready",     64'(ready),        64'd1);
        check("rst.we_n",      64'(WE_N_SRAM),    64'd1);
        check("rst.addr_err",  64'(addr_err),     64'd0);
        check("rst.read_data", 64'(read_data),    64'd0);
        check("rst.addr_sram", 64'(address_SRAM), 64'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 1'b1, o);
            model_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e);
            cmp_obs($sformatf("vec%0d", i), o, vecs[i].e);
        end

        // Back-to-back writes with the request held across DONE.
        run_txn(1'b0, 1'b1, 32'd1024, 32'h11111111, 1'b0, 1'b0, o);
        model_txn(1'b0, 1'b1, 32'd1024, 32'h11111111, e);
        cmp_obs("b2b0", o, '{6, 4, 1'b0, 32'hA5A50001, 16'd0});
        run_txn(1'b0, 1'b1, 32'd1028, 32'h22222222, 1'b0, 1'b1, o);
        model_txn(1'b0, 1'b1, 32'd1028, 32'h22222222, e);
        cmp_obs("b2b1", o, '{6, 4, 1'b0, 32'hA5A50001, 16'd1});
        run_txn(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1, o);
        model_txn(1'b1, 1'b0, 32'd1024, 32'h0, e);
        check("b2b.word0", 64'(o.rdata), 64'h11111111);
        run_txn(1'b1, 1'b0, 32'd1029, 32'h0, 1'b1, 1'b1, o);
        model_txn(1'b1, 1'b0, 32'd1029, 32'h0, e);
        check("b2b.word1", 64'(o.rdata), 64'h22222222);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic rd, wr;
            bit scr, drp;
            int kind = int'($urandom_range(0, 5));
            int op   = int'($urandom_range(0, 2));
            case (kind)
                0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                3:       a = BASE + ($urandom & 32'h3FFFF);
                4:       a = 32'($urandom_range(0, int'(BASE) - 1));
                default: a = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h80000000)
                                                         : (BASE + 32'h40000 + ($urandom & 32'hFFFF));
            endcase
            rd  = (op != 1);
            wr  = (op != 0);
            scr = ($urandom_range(0, 3) == 0);
            drp = scr || ($urandom_range(0, 1) == 1);
            run_txn(rd, wr, a, $urandom, scr, drp, o);
            model_txn(rd, wr, a, write_data, e);
            cmp_obs($sformatf("rnd%0d", n), o, e);
        end

        // Reset in the middle of a write: the access is abandoned for good.
        @(negedge clk);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D; sram_oe = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.we_before", 64'(WE_N_SRAM), 64'd0);
        rst = 1'b1; MEM_W_EN = 1'b0;
        #1;
        check("midrst.we_n",      64'(WE_N_SRAM),    64'd1);
        check("midrst.ready",     64'(ready),        64'd1);
        check("midrst.addr_err",  64'(addr_err),     64'd0);
        check("midrst.read_data", 64'(read_data),    64'd0);
        check("midrst.addr_sram", 64'(address_SRAM), 64'd0);
        @(negedge clk); rst = 1'b0;
        cnt_lo = 0; cnt_we = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!ready) cnt_lo++;
            if (!WE_N_SRAM) cnt_we++;
        end
        check("midrst.no_retry_ready", 64'(cnt_lo), 64'd0);
        check("midrst.no_retry_we",    64'(cnt_we), 64'd0);
        m_rdata = '0; m_asram = '0;

        run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b1, o);
        model_txn(1'b1, 1'b0, 32'd1032, 32'h0, e);
        cmp_obs("postrst", o, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
